// File: rtl/cone_drv_pkg.sv
// Shared definitions for the cone vector driver.
//
// Contents:
//   state_t   - driver FSM states (SHIFT, APPLY, CAPTURE, REPORT)
//   frame_len - serial frame length for a given vector width.
//               The length is VEC_W+1 when CONE_DRV_GOLDEN_CMP_EN is defined
//               (a trailing expected bit is added), and VEC_W otherwise.
package cone_drv_pkg;

    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    function automatic int frame_len(input int vec_w);
`ifdef CONE_DRV_GOLDEN_CMP_EN
        return vec_w + 1;
`else
        return vec_w;
`endif
    endfunction

endpackage

// File: rtl/cone_drv_shift.sv
// Serial frame assembler for the cone vector driver.
//
// Bits arrive LSB first. Each new bit enters at the MSB and the register
// shifts right, so after a full frame bit k of the frame sits at index k.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   shift_en   in   a frame bit transfers this cycle
//   bit_in     in   the frame bit
//   frame      out  assembled frame, frame_len(VEC_W) bits
//   frame_done out  pulse: this transfer carries the last frame bit
module cone_drv_shift
    import cone_drv_pkg::*;
#(
    parameter int VEC_W = 31
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        shift_en,
    input  logic                        bit_in,
    output logic [frame_len(VEC_W)-1:0] frame,
    output logic                        frame_done
);

    localparam int FL = frame_len(VEC_W);
    localparam int CW = $clog2(FL);

    logic [CW-1:0] bit_cnt;
    logic          last_bit;

    assign last_bit   = (bit_cnt == CW'(FL - 1));
    assign frame_done = shift_en && last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            frame   <= {bit_in, frame[FL-1:1]};
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cone_vector_driver.sv
// Stimulus driver and response capturer for a single-output combinational
// cone. A serial frame is assembled, applied to the cone as a stable vector,
// and after SETTLE cycles the cone output is sampled and reported.
//
// Optional feature macro: CONE_DRV_GOLDEN_CMP_EN
//   defined   - frame carries a trailing expected bit; res_mismatch and the
//               saturating err_cnt report disagreement with the cone output.
//   undefined - no compare logic; res_mismatch and err_cnt are constant 0
//               and err_clr is ignored.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its data until that edge and ready never depends
// on valid.
//
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   si_valid/si_data/si_ready   serial frame bit input handshake
//   vec_o         vector applied to the cone (changes only on APPLY entry)
//   resp_i        cone output
//   res_valid/res_data/res_mismatch/res_ready   result output handshake
//   err_clr       synchronous clear of err_cnt (wins over an increment)
//   err_cnt       saturating mismatch count
//   busy          high in every state except SHIFT
//   state         FSM state, exposed for debug
module cone_vector_driver
    import cone_drv_pkg::*;
#(
    parameter int VEC_W  = 31,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si_valid,
    input  logic             si_data,
    output logic             si_ready,
    output logic [VEC_W-1:0] vec_o,
    input  logic             resp_i,
    output logic             res_valid,
    output logic             res_data,
    output logic             res_mismatch,
    input  logic             res_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy,
    output state_t           state
);

    localparam int FL = frame_len(VEC_W);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [FL-1:0] frame;
    logic          frame_done;
    logic          shift_en;
    logic [SW-1:0] settle_cnt;

    assign si_ready = (state == SHIFT);
    assign busy     = (state != SHIFT);
    assign shift_en = si_valid && si_ready;

    cone_drv_shift #(
        .VEC_W(VEC_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .bit_in    (si_data),
        .frame     (frame),
        .frame_done(frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SHIFT;
            settle_cnt <= '0;
            vec_o      <= '0;
            res_valid  <= 1'b0;
            res_data   <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (frame_done) state <= APPLY;
                end
                APPLY: begin
                    // The first APPLY cycle loads the vector; the remaining
                    // cycles only let the cone settle.
                    if (settle_cnt == '0) vec_o <= frame[VEC_W-1:0];
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                CAPTURE: begin
                    res_data  <= resp_i;
                    res_valid <= 1'b1;
                    state     <= REPORT;
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

`ifdef CONE_DRV_GOLDEN_CMP_EN
    logic expected_bit;
    logic mismatch_now;

    assign expected_bit = frame[VEC_W];
    assign mismatch_now = resp_i ^ expected_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_mismatch <= 1'b0;
        end else if (state == CAPTURE) begin
            res_mismatch <= mismatch_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if ((state == CAPTURE) && mismatch_now && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign res_mismatch   = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule
